ps2_scancode_decoder: RTL and testbench

//  Sits directly downstream of the PS/2 keyboard receiver FIFO. Pops raw scan-code bytes

---
 rtl/ps2_scancode_decoder_if.sv | 10 +
 rtl/ps2_scancode_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Byte handshake between the PS/2 receiver FIFO (master) and the scan-code decoder (slave).
// data is valid while ready=1; the slave pops one byte by driving nextdata_n low for one cycle.
interface ps2_scancode_decoder_if;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;

    modport master (output data, output ready, input nextdata_n);
    modport slave  (input data, input ready, output nextdata_n);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, strips E0/F0/E1 prefixes,
// and emits one-cycle key events with held-key, shift and press-count tracking.
module ps2_scancode_decoder #(
    parameter int PCNT_W   = 8,
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    ps2_scancode_decoder_if.slave rx,
    output logic              key_valid,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic              key_release,
    output logic              key_repeat,
    output logic [7:0]        key_ascii,
    output logic              key_held,
    output logic [7:0]        held_code,
    output logic              shift_held,
    output logic [PCNT_W-1:0] press_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          byte_q, byte_d;
    logic                nextdata_n_q, nextdata_n_d;
    logic [2:0]          skip_cnt_q, skip_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                key_valid_q, key_valid_d;
    logic [7:0]          key_code_q, key_code_d;
    logic                key_ext_q, key_ext_d;
    logic                key_release_q, key_release_d;
    logic                key_repeat_q, key_repeat_d;
    logic [7:0]          key_ascii_q, key_ascii_d;
    logic                key_held_q, key_held_d;
    logic                held_ext_q, held_ext_d;
    logic [7:0]          held_code_q, held_code_d;
    logic                shift_l_q, shift_l_d;
    logic                shift_r_q, shift_r_d;
    logic [PCNT_W-1:0]   press_count_q, press_count_d;
    logic                held_match;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] base;
        logic [4:0] idx;
        logic       is_letter;
        logic [7:0] res;
        base      = upper ? 8'h41 : 8'h61;
        idx       = 5'd0;
        is_letter = 1'b1;
        res       = 8'h00;
        case (code)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            res = base + {3'b000, idx};
        end else begin
            case (code)
                8'h45: res = 8'h30;  8'h16: res = 8'h31;  8'h1E: res = 8'h32;
                8'h26: res = 8'h33;  8'h25: res = 8'h34;  8'h2E: res = 8'h35;
                8'h36: res = 8'h36;  8'h3D: res = 8'h37;  8'h3E: res = 8'h38;
                8'h46: res = 8'h39;  8'h29: res = 8'h20;  8'h5A: res = 8'h0D;
                8'h66: res = 8'h08;  8'h0D: res = 8'h09;
                default: res = 8'h00;
            endcase
        end
        return res;
    endfunction

    assign held_match = key_held_q && (held_ext_q == ext_q) && (held_code_q == byte_q);

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = 1'b1;
        skip_cnt_d    = skip_cnt_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_release_d = key_release_q;
        key_repeat_d  = key_repeat_q;
        key_ascii_d   = key_ascii_q;
        key_held_d    = key_held_q;
        held_ext_d    = held_ext_q;
        held_code_d   = held_code_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        press_count_d = press_count_q;

        case (state_q)
            S_IDLE: begin
                if (rx.ready) begin
                    byte_d       = rx.data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_IDLE;
                // Pause (E1) tail bytes are swallowed whole, even ones that look like prefixes.
                if (skip_cnt_q != 3'd0) begin
                    skip_cnt_d = skip_cnt_q - 3'd1;
                end else if (byte_q == 8'hE1) begin
                    skip_cnt_d = 3'd7;
                    ext_d      = 1'b0;
                    brk_d      = 1'b0;
                end else if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (byte_q == 8'h00 || byte_q == 8'hAA || byte_q == 8'hEE ||
                             byte_q == 8'hFA || byte_q == 8'hFE || byte_q == 8'hFF) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    key_valid_d   = 1'b1;
                    key_code_d    = byte_q;
                    key_ext_d     = ext_q;
                    key_release_d = brk_q;
                    key_ascii_d   = ext_q ? 8'h00 : ascii_of(byte_q, SHIFT_EN && (shift_l_q || shift_r_q));
                    ext_d         = 1'b0;
                    brk_d         = 1'b0;
                    if (!brk_q) begin
                        key_repeat_d = held_match;
                        if (!held_match) begin
                            key_held_d    = 1'b1;
                            held_ext_d    = ext_q;
                            held_code_d   = byte_q;
                            press_count_d = press_count_q + PCNT_W'(1);
                        end
                        if (!ext_q && byte_q == 8'h12) shift_l_d = 1'b1;
                        if (!ext_q && byte_q == 8'h59) shift_r_d = 1'b1;
                    end else begin
                        key_repeat_d = 1'b0;
                        if (held_match) begin
                            key_held_d  = 1'b0;
                            held_ext_d  = 1'b0;
                            held_code_d = 8'h00;
                        end
                        if (!ext_q && byte_q == 8'h12) shift_l_d = 1'b0;
                        if (!ext_q && byte_q == 8'h59) shift_r_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            skip_cnt_q    <= 3'd0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_ascii_q   <= 8'h00;
            key_held_q    <= 1'b0;
            held_ext_q    <= 1'b0;
            held_code_q   <= 8'h00;
            shift_l_q     <= 1'b0;
            shift_r_q     <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            skip_cnt_q    <= skip_cnt_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_release_q <= key_release_d;
            key_repeat_q  <= key_repeat_d;
            key_ascii_q   <= key_ascii_d;
            key_held_q    <= key_held_d;
            held_ext_q    <= held_ext_d;
            held_code_q   <= held_code_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            press_count_q <= press_count_d;
        end
    end

    assign rx.nextdata_n = nextdata_n_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_release   = key_release_q;
    assign key_repeat    = key_repeat_q;
    assign key_ascii     = key_ascii_q;
    assign key_held      = key_held_q;
    assign held_code     = held_code_q;
    assign shift_held    = shift_l_q || shift_r_q;
    assign press_count   = press_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: a byte FIFO model feeds two decoders (8-bit and 2-bit press counters)
// with the same stream; a per-byte vector table plus hand sequences check the events.
module tb_ps2_scancode_decoder;

  logic clk;
  logic rst;
  logic [7:0] data_drv;
  logic ready_drv;
  logic [7:0] fifo[$];
  int checks;
  int errors;

  ps2_scancode_decoder_if rx_if ();
  ps2_scancode_decoder_if rx_if_w ();
  assign rx_if.data    = data_drv;
  assign rx_if.ready   = ready_drv;
  assign rx_if_w.data  = data_drv;
  assign rx_if_w.ready = ready_drv;

  logic       key_valid, key_ext, key_release, key_repeat, key_held, shift_held;
  logic [7:0] key_code, key_ascii, held_code, press_count;
  logic [1:0] dbg_state;
  logic       w_key_valid, w_key_ext, w_key_release, w_key_repeat, w_key_held, w_shift_held;
  logic [7:0] w_key_code, w_key_ascii, w_held_code;
  logic [1:0] w_press_count, w_dbg_state;

  ps2_scancode_decoder #(.PCNT_W(8), .SHIFT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_if.slave),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_repeat(key_repeat), .key_ascii(key_ascii),
    .key_held(key_held), .held_code(held_code), .shift_held(shift_held),
    .press_count(press_count), .dbg_state(dbg_state)
  );

  ps2_scancode_decoder #(.PCNT_W(2), .SHIFT_EN(1'b1)) u_dut_w (
    .clk(clk), .rst(rst), .rx(rx_if_w.slave),
    .key_valid(w_key_valid), .key_code(w_key_code), .key_ext(w_key_ext),
    .key_release(w_key_release), .key_repeat(w_key_repeat), .key_ascii(w_key_ascii),
    .key_held(w_key_held), .held_code(w_held_code), .shift_held(w_shift_held),
    .press_count(w_press_count), .dbg_state(w_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver FIFO model: pop on nextdata_n low at the edge, update head just after
  always @(posedge clk) begin
    if (rx_if.nextdata_n === 1'b0 && fifo.size() > 0) fifo.delete(0);
    #1;
    ready_drv = (fifo.size() != 0);
    data_drv  = ready_drv ? fifo[0] : 8'h00;
  end

  typedef struct {
    logic [7:0] din;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] asc;
    logic       held;
    logic [7:0] hcode;
    logic       shift;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_ev(input logic [7:0] din, input logic [7:0] code, input logic ext,
                        input logic rel, input logic rep, input logic [7:0] asc,
                        input logic held, input logic [7:0] hcode, input logic shift,
                        input logic [7:0] cnt);
    vec_t v;
    v = '{din, 1'b1, code, ext, rel, rep, asc, held, hcode, shift, cnt};
    vecs.push_back(v);
  endtask

  task automatic add_nv(input logic [7:0] din, input logic held, input logic [7:0] hcode,
                        input logic shift, input logic [7:0] cnt);
    vec_t v;
    v = '{din, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, held, hcode, shift, cnt};
    vecs.push_back(v);
  endtask

  // driver: queue one byte, wait for its POP cycle, then step to the event cycle
  task automatic apply_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    fifo.push_back(b);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_if.nextdata_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL pop_timeout: byte %0h never popped", b);
    end else begin
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int pop_cyc[$];
    logic [7:0] ev_code[$];
    logic       ev_rel[$];
    logic [7:0] make5[5];

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    ready_drv = 1'b0;
    data_drv  = 8'h00;

    // T2/T3/T4/T5 and extras, one row per byte
    add_ev(8'h1C, 8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 1);
    add_nv(8'hF0, 1, 8'h1C, 0, 1);
    add_ev(8'h1C, 8'h1C, 0, 1, 0, 8'h61, 0, 8'h00, 0, 1);
    add_nv(8'hE0, 0, 8'h00, 0, 1);
    add_ev(8'h75, 8'h75, 1, 0, 0, 8'h00, 1, 8'h75, 0, 2);
    add_nv(8'hE0, 1, 8'h75, 0, 2);
    add_nv(8'hF0, 1, 8'h75, 0, 2);
    add_ev(8'h75, 8'h75, 1, 1, 0, 8'h00, 0, 8'h00, 0, 2);
    add_ev(8'h1C, 8'h1C, 0, 0, 0, 8'h61, 1, 8'h1C, 0, 3);
    add_ev(8'h1C, 8'h1C, 0, 0, 1, 8'h61, 1, 8'h1C, 0, 3);
    add_ev(8'h1C, 8'h1C, 0, 0, 1, 8'h61, 1, 8'h1C, 0, 3);
    add_nv(8'hF0, 1, 8'h1C, 0, 3);
    add_ev(8'h1C, 8'h1C, 0, 1, 0, 8'h61, 0, 8'h00, 0, 3);
    add_ev(8'h12, 8'h12, 0, 0, 0, 8'h00, 1, 8'h12, 1, 4);
    add_ev(8'h1C, 8'h1C, 0, 0, 0, 8'h41, 1, 8'h1C, 1, 5);
    add_nv(8'hF0, 1, 8'h1C, 1, 5);
    add_ev(8'h12, 8'h12, 0, 1, 0, 8'h00, 1, 8'h1C, 0, 5);
    add_ev(8'h1C, 8'h1C, 0, 0, 1, 8'h61, 1, 8'h1C, 0, 5);
    add_nv(8'hF0, 1, 8'h1C, 0, 5);
    add_ev(8'h1C, 8'h1C, 0, 1, 0, 8'h61, 0, 8'h00, 0, 5);
    add_nv(8'hE1, 0, 8'h00, 0, 5);
    add_nv(8'h14, 0, 8'h00, 0, 5);
    add_nv(8'h77, 0, 8'h00, 0, 5);
    add_nv(8'hE1, 0, 8'h00, 0, 5);
    add_nv(8'hF0, 0, 8'h00, 0, 5);
    add_nv(8'h14, 0, 8'h00, 0, 5);
    add_nv(8'hF0, 0, 8'h00, 0, 5);
    add_nv(8'h77, 0, 8'h00, 0, 5);
    add_ev(8'h29, 8'h29, 0, 0, 0, 8'h20, 1, 8'h29, 0, 6);
    add_nv(8'hF0, 1, 8'h29, 0, 6);
    add_ev(8'h29, 8'h29, 0, 1, 0, 8'h20, 0, 8'h00, 0, 6);
    add_nv(8'hE0, 0, 8'h00, 0, 6);
    add_nv(8'hAA, 0, 8'h00, 0, 6);
    add_ev(8'h75, 8'h75, 0, 0, 0, 8'h00, 1, 8'h75, 0, 7);
    add_nv(8'hF0, 1, 8'h75, 0, 7);
    add_ev(8'h75, 8'h75, 0, 1, 0, 8'h00, 0, 8'h00, 0, 7);
    add_ev(8'h45, 8'h45, 0, 0, 0, 8'h30, 1, 8'h45, 0, 8);
    add_nv(8'hF0, 1, 8'h45, 0, 8);
    add_ev(8'h45, 8'h45, 0, 1, 0, 8'h30, 0, 8'h00, 0, 8);
    add_ev(8'h5A, 8'h5A, 0, 0, 0, 8'h0D, 1, 8'h5A, 0, 9);
    add_nv(8'hF0, 1, 8'h5A, 0, 9);
    add_ev(8'h5A, 8'h5A, 0, 1, 0, 8'h0D, 0, 8'h00, 0, 9);
    add_ev(8'h59, 8'h59, 0, 0, 0, 8'h00, 1, 8'h59, 1, 10);
    add_ev(8'h1C, 8'h1C, 0, 0, 0, 8'h41, 1, 8'h1C, 1, 11);
    add_nv(8'hF0, 1, 8'h1C, 1, 11);
    add_ev(8'h59, 8'h59, 0, 1, 0, 8'h00, 1, 8'h1C, 0, 11);
    add_nv(8'hF0, 1, 8'h1C, 0, 11);
    add_ev(8'h1C, 8'h1C, 0, 1, 0, 8'h61, 0, 8'h00, 0, 11);

    // T1: reset held two cycles with a byte waiting
    fifo.push_back(8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nextdata_n", rx_if.nextdata_n, 1'b1);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_press_count", press_count, 8'd0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_key_held", key_held, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_after_filler", dbg_state, 2'd0);

    foreach (vecs[i]) begin
      apply_byte(vecs[i].din, ok);
      if (ok) begin
        chk($sformatf("v%0d_valid", i), key_valid, vecs[i].ev);
        if (vecs[i].ev) begin
          chk($sformatf("v%0d_code", i), key_code, vecs[i].code);
          chk($sformatf("v%0d_ext", i), key_ext, vecs[i].ext);
          chk($sformatf("v%0d_rel", i), key_release, vecs[i].rel);
          chk($sformatf("v%0d_rep", i), key_repeat, vecs[i].rep);
          chk($sformatf("v%0d_ascii", i), key_ascii, vecs[i].asc);
        end
        chk($sformatf("v%0d_held", i), key_held, vecs[i].held);
        chk($sformatf("v%0d_hcode", i), held_code, vecs[i].hcode);
        chk($sformatf("v%0d_shift", i), shift_held, vecs[i].shift);
        chk($sformatf("v%0d_cnt", i), press_count, vecs[i].cnt);
        chk($sformatf("v%0d_cnt_w", i), w_press_count, vecs[i].cnt[1:0]);
        @(negedge clk);
        chk($sformatf("v%0d_pulse", i), key_valid, 1'b0);
      end
    end

    // T2 back-to-back: three pops 3 cycles apart, two events
    fifo.push_back(8'h1C);
    fifo.push_back(8'hF0);
    fifo.push_back(8'h1C);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rx_if.nextdata_n === 1'b0) pop_cyc.push_back(c);
      if (key_valid === 1'b1) begin
        ev_code.push_back(key_code);
        ev_rel.push_back(key_release);
      end
    end
    chk("bb_pop_count", pop_cyc.size(), 3);
    chk("bb_event_count", ev_code.size(), 2);
    if (pop_cyc.size() == 3) begin
      chk("bb_gap1", pop_cyc[1] - pop_cyc[0], 3);
      chk("bb_gap2", pop_cyc[2] - pop_cyc[1], 3);
    end
    if (ev_code.size() == 2) begin
      chk("bb_ev0_code", ev_code[0], 8'h1C);
      chk("bb_ev0_rel", ev_rel[0], 1'b0);
      chk("bb_ev1_code", ev_code[1], 8'h1C);
      chk("bb_ev1_rel", ev_rel[1], 1'b1);
    end
    chk("bb_held", key_held, 1'b0);
    chk("bb_cnt", press_count, 8'd12);

    // T6: counter wrap after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_cnt", press_count, 8'd0);
    make5 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    foreach (make5[i]) apply_byte(make5[i], ok);
    chk("wrap_cnt8", press_count, 8'd5);
    chk("wrap_cnt2", w_press_count, 2'd1);
    chk("wrap_held_code", held_code, 8'h2C);

    // T6: reset during POP
    fifo.push_back(8'h1C);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rx_if.nextdata_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pop_seen", ok, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midpop_nextdata_n", rx_if.nextdata_n, 1'b1);
    chk("midpop_state", dbg_state, 2'd0);
    chk("midpop_cnt", press_count, 8'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_held", key_held, 1'b0);
    chk("post_rst_state", dbg_state, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
